round_robin_arbiter: RTL and testbench

- Shares one downstream resource (e.g. an encoder or adder datapath) between N requesters.
- Grants one requester at a time, holds the grant until the owner releases it, drops its request or exceeds a hold limit, then rearbitrates.
- Selectable fixed-priority or round-robin policy.
- Sits between requester blocks and the shared resource; `gnt_idx` drives the resource input mux.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 41 ++++
 rtl/round_robin_arbiter.sv | 123 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the round-robin arbiter: FSM states and policy select values.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    TURN = 2'b10
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: lowest set index (fixed) or first set index at/after
// `start`, wrapping modulo N (round robin).
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // NOTE: every output gets a default before the search loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      if (mode == MODE_FIXED) begin
        cand = k;
      end else begin
        cand = int'(start) + k;
        if (cand >= N) cand = cand - N;
      end
      if (!any && req[IDX_W'(cand)]) begin
        any = 1'b1;
        idx = IDX_W'(cand);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-way arbiter with grant hold, hold-limit timeout and a one-cycle turnaround
// between owners; fixed-priority or round-robin policy chosen at each arbitration.
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             release_in,  // "release" is a reserved word in SystemVerilog
  input  logic             mode,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [IDX_W-1:0]  start;
  logic [N-1:0]      pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              voluntary;
  logic              expired;

  // Round-robin search begins just past the last winner.
  assign start = (ptr_q == IDX_W'(N - 1)) ? '0 : ptr_q + 1'b1;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .start  (start),
    .mode   (mode),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign voluntary = release_in | ~req[gnt_idx_q];
  assign expired   = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    case (state_q)
      BUSY: begin
        if (voluntary || expired) begin
          state_d     = TURN;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_d      = '0;
          // A voluntary exit on the expiry cycle is not reported as a timeout.
          timeout_d   = ~voluntary;
        end else if ((HOLD_MAX != 0) && (hold_q != HOLD_LIM)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        // IDLE and TURN both arbitrate on the sampled request vector.
        gnt_d       = pick_onehot;
        gnt_idx_d   = pick_idx;
        gnt_valid_d = pick_any;
        if (pick_any) begin
          state_d = BUSY;
          ptr_d   = pick_idx;
          hold_d  = HOLD_W'(1);
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= '0;
      ptr_q       <= IDX_W'(N - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the arbitration rules.
module tb_round_robin_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         release_in = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: who owns the resource, for how long, and who won last.
  bit m_busy;
  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_timeout;

  round_robin_arbiter #(
    .N        (N),
    .IDX_W    (2),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_in (release_in),
    .mode       (mode),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [N-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_busy    = 0;
    m_owner   = 0;
    m_hold    = 0;
    m_ptr     = N - 1;
    m_timeout = 0;
  endtask

  task automatic model_step();
    int w;
    bit vol;
    bit exp_to;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      m_timeout = 0;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mode ? (m_ptr + 1 + k) : k) % N;
        if (w < 0 && req[i]) w = i;
      end
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_ptr   = w;
        m_hold  = 1;
      end
    end else begin
      vol    = release_in || !req[m_owner];
      exp_to = (HOLD_MAX != 0) && (m_hold >= HOLD_MAX);
      if (vol || exp_to) begin
        m_busy    = 0;
        m_timeout = !vol;
        m_hold    = 0;
      end else begin
        m_timeout = 0;
        if (m_hold < HOLD_MAX) m_hold++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = '0;
    release_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async outs=%b required=%b", {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
        n_err++;
        $display("FAIL reset_idle c=%0d outs=%b required=%b", c, {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
      end
    end
  endtask

  task automatic test_fixed();
    logic [N-1:0] t_req [8] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic         t_rel [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] t_gnt [8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [N-1:0] e;
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      req        = t_req[s];
      release_in = t_rel[s];
      tick();
      e = t_gnt[s];
      n_vec++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {e, oh2idx(e), |e, 1'b0}) begin
        n_err++;
        $display("FAIL fixed s=%0d outs=%b required=%b", s, {gnt, gnt_idx, gnt_valid, timeout}, {e, oh2idx(e), |e, 1'b0});
      end
    end
  endtask

  task automatic test_rr();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] e;
    do_reset();
    mode = 1'b1;
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int s = 0; s < 3; s++) begin
        release_in = (s == 2);
        tick();
        e = (s == 2) ? 4'b0000 : 4'(1 << order[g]);
        n_vec++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {e, oh2idx(e), |e, 1'b0}) begin
          n_err++;
          $display("FAIL rr g=%0d s=%0d outs=%b required=%b", g, s, {gnt, gnt_idx, gnt_valid, timeout}, {e, oh2idx(e), |e, 1'b0});
        end
      end
    end
    release_in = 1'b0;
    req        = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] e;
    logic         et;
    do_reset();
    mode = 1'b1;
    req  = 4'b0011;
    for (int s = 0; s < 12; s++) begin
      if (s == 10) req = 4'b0000;
      tick();
      e  = (s < 8) ? 4'b0001 : (s == 9) ? 4'b0010 : 4'b0000;
      et = (s == 8);
      n_vec++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {e, oh2idx(e), |e, et}) begin
        n_err++;
        $display("FAIL timeout s=%0d outs=%b required=%b", s, {gnt, gnt_idx, gnt_valid, timeout}, {e, oh2idx(e), |e, et});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] e;
    do_reset();
    mode = 1'b1;
    req  = 4'b0011;
    for (int s = 0; s < 14; s++) begin
      release_in = (s == 8) || (s >= 10 && s < 13);
      if (s == 9) req = 4'b0000;
      if (s == 13) req = 4'b0100;
      tick();
      e = (s < 8) ? 4'b0001 : (s == 13) ? 4'b0100 : 4'b0000;
      n_vec++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {e, oh2idx(e), |e, 1'b0}) begin
        n_err++;
        $display("FAIL simult s=%0d outs=%b required=%b", s, {gnt, gnt_idx, gnt_valid, timeout}, {e, oh2idx(e), |e, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL async_pre gnt=%b required=%b", gnt, 4'b0100);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL async_clear outs=%b required=%b", {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
    end
    mode = 1'b1;
    req  = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_first_rr outs=%b required=%b", {gnt, gnt_idx, gnt_valid, timeout}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    logic [1:0]   ei;
    do_reset();
    mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
      release_in = ($urandom_range(4) == 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      tick();
      e  = m_busy ? 4'(1 << m_owner) : 4'b0000;
      ei = m_busy ? 2'(m_owner) : 2'd0;
      n_vec++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {e, ei, m_busy, m_timeout}) begin
        n_err++;
        $display("FAIL random c=%0d outs=%b required=%b", c, {gnt, gnt_idx, gnt_valid, timeout}, {e, ei, m_busy, m_timeout});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_rr();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
